// File: rtl/warp_fetch_scheduler.sv
// Round-robin fetch scheduler: picks one ready warp per cycle and registers an
// instruction-fetch request (wid, pc, active mask) behind a valid/ready slot.
module warp_fetch_scheduler #(
    parameter int unsigned PcWidth   = 32,
    parameter int unsigned NumWarps  = 32,
    parameter int unsigned WarpWidth = 32,
    parameter int unsigned WidWidth  = NumWarps > 1 ? $clog2(NumWarps) : 1,
    parameter type wid_t      = logic [WidWidth-1:0],
    parameter type pc_t       = logic [PcWidth-1:0],
    parameter type act_mask_t = logic [WarpWidth-1:0]
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic      [NumWarps-1:0]     warp_ready_i,
    input  pc_t       [NumWarps-1:0]     warp_pc_i,
    input  act_mask_t [NumWarps-1:0]     warp_act_mask_i,
    output logic      [NumWarps-1:0]     warp_selected_o,
    output logic                         fetch_valid_o,
    input  logic                         fetch_ready_i,
    output wid_t                         fetch_wid_o,
    output pc_t                          fetch_pc_o,
    output act_mask_t                    fetch_act_mask_o
);

    wid_t                last_wid_reg, last_wid_next;
    logic                valid_next;
    wid_t                wid_next;
    pc_t                 pc_next;
    act_mask_t           mask_next;
    logic [NumWarps-1:0] upper_mask;
    logic [NumWarps-1:0] upper_ready;
    wid_t                cand;
    logic                cand_valid;
    logic                slot_free;
    logic                grant;

    // Warps numbered above last_wid get first pick; the rest form the wrap-around.
    for (genvar gi = 0; gi < NumWarps; gi++) begin : g_upper
        assign upper_mask[gi] = (gi > int'(last_wid_reg));
    end

    assign upper_ready = warp_ready_i & upper_mask;
    assign cand_valid  = |warp_ready_i;
    assign slot_free   = !fetch_valid_o || fetch_ready_i;
    assign grant       = cand_valid && slot_free;

    // Lowest ready warp overall, overridden by the lowest one above last_wid.
    always_comb begin
        cand = '0;
        for (int i = NumWarps - 1; i >= 0; i--) begin
            if (warp_ready_i[i]) cand = wid_t'(i);
        end
        for (int i = NumWarps - 1; i >= 0; i--) begin
            if (upper_ready[i]) cand = wid_t'(i);
        end
    end

    for (genvar gi = 0; gi < NumWarps; gi++) begin : g_sel
        assign warp_selected_o[gi] = grant && (int'(cand) == gi);
    end

    always_comb begin
        valid_next    = fetch_valid_o;
        wid_next      = fetch_wid_o;
        pc_next       = fetch_pc_o;
        mask_next     = fetch_act_mask_o;
        last_wid_next = last_wid_reg;
        if (grant) begin
            valid_next    = 1'b1;
            wid_next      = cand;
            pc_next       = warp_pc_i[cand];
            mask_next     = warp_act_mask_i[cand];
            last_wid_next = cand;
        end else if (fetch_ready_i) begin
            valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fetch_valid_o    <= 1'b0;
            fetch_wid_o      <= '0;
            fetch_pc_o       <= '0;
            fetch_act_mask_o <= '0;
            last_wid_reg     <= wid_t'(NumWarps - 1);
        end else begin
            fetch_valid_o    <= valid_next;
            fetch_wid_o      <= wid_next;
            fetch_pc_o       <= pc_next;
            fetch_act_mask_o <= mask_next;
            last_wid_reg     <= last_wid_next;
        end
    end

`ifndef SYNTHESIS
    a_sel_onehot: assert property (@(posedge clk_i) disable iff (!rst_ni)
        $onehot0(warp_selected_o));
    a_sel_ready: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (warp_selected_o & ~warp_ready_i) == '0);
    a_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        (fetch_valid_o && !fetch_ready_i) |=>
            (fetch_valid_o && $stable({fetch_wid_o, fetch_pc_o, fetch_act_mask_o})));
`endif

endmodule

// File: tb/tb_warp_fetch_scheduler.sv
// Directed bench for warp_fetch_scheduler with four warps: vector table plus
// hand-written backpressure, async-reset and round-robin sequences.
module tb_warp_fetch_scheduler;

    localparam int NW = 4;

    logic              clk_i = 1'b0;
    logic              rst_ni = 1'b0;
    logic [NW-1:0]     warp_ready_i = '0;
    logic [NW-1:0][15:0] warp_pc_i;
    logic [NW-1:0][7:0]  warp_act_mask_i;
    logic [NW-1:0]     warp_selected_o;
    logic              fetch_valid_o;
    logic              fetch_ready_i = 1'b0;
    logic [1:0]        fetch_wid_o;
    logic [15:0]       fetch_pc_o;
    logic [7:0]        fetch_act_mask_o;

    int errors = 0;
    int checks = 0;

    warp_fetch_scheduler #(
        .PcWidth   (16),
        .NumWarps  (NW),
        .WarpWidth (8)
    ) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .warp_ready_i     (warp_ready_i),
        .warp_pc_i        (warp_pc_i),
        .warp_act_mask_i  (warp_act_mask_i),
        .warp_selected_o  (warp_selected_o),
        .fetch_valid_o    (fetch_valid_o),
        .fetch_ready_i    (fetch_ready_i),
        .fetch_wid_o      (fetch_wid_o),
        .fetch_pc_o       (fetch_pc_o),
        .fetch_act_mask_o (fetch_act_mask_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0] ready;
        logic       fr;
        logic [3:0] sel;
        logic       valid;
        logic [1:0] wid;
    } vec_t;

    vec_t tbl[12];

    function automatic logic [15:0] pc_of(input int w);
        return 16'(w * 32);
    endfunction

    function automatic logic [7:0] mask_of(input int w);
        return 8'hA0 | 8'(w);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_slot(input string name, input logic v, input int w);
        check({name, ".valid"}, 64'(fetch_valid_o), 64'(v));
        if (v) begin
            check({name, ".wid"},  64'(fetch_wid_o), 64'(w));
            check({name, ".pc"},   64'(fetch_pc_o), 64'(pc_of(w)));
            check({name, ".mask"}, 64'(fetch_act_mask_o), 64'(mask_of(w)));
        end
    endtask

    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    logic [3:0] sel_seen;
    int         rearm_at[NW];
    int         order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    initial begin
        for (int w = 0; w < NW; w++) begin
            warp_pc_i[w]       = pc_of(w);
            warp_act_mask_i[w] = mask_of(w);
        end

        tbl[0]  = '{4'b1010, 1'b1, 4'b0010, 1'b0, 2'd0};
        tbl[1]  = '{4'b1000, 1'b0, 4'b0000, 1'b1, 2'd1};
        tbl[2]  = '{4'b1000, 1'b1, 4'b1000, 1'b1, 2'd1};
        tbl[3]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3};
        tbl[4]  = '{4'b0101, 1'b1, 4'b0001, 1'b0, 2'd0};
        tbl[5]  = '{4'b0100, 1'b0, 4'b0000, 1'b1, 2'd0};
        tbl[6]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 2'd0};
        tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd2};
        tbl[8]  = '{4'b1011, 1'b1, 4'b1000, 1'b0, 2'd0};
        tbl[9]  = '{4'b0011, 1'b1, 4'b0001, 1'b1, 2'd3};
        tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0};
        tbl[11] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0};

        // Reset held low, then idle
        #2;
        check("rst.valid", 64'(fetch_valid_o), 64'd0);
        check("rst.wid",   64'(fetch_wid_o), 64'd0);
        check("rst.pc",    64'(fetch_pc_o), 64'd0);
        check("rst.mask",  64'(fetch_act_mask_o), 64'd0);
        check("rst.sel",   64'(warp_selected_o), 64'd0);
        next_cycle();
        next_cycle();
        rst_ni = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i);
            check("idle.valid", 64'(fetch_valid_o), 64'd0);
            check("idle.sel",   64'(warp_selected_o), 64'd0);
            next_cycle();
        end

        // Vector table: first grant, stall, drain with and without candidate
        for (int i = 0; i < 12; i++) begin
            warp_ready_i  = tbl[i].ready;
            fetch_ready_i = tbl[i].fr;
            @(negedge clk_i);
            $display("vec %0d ready=%b fr=%b sel=%b valid=%b wid=%0d",
                     i, tbl[i].ready, tbl[i].fr, warp_selected_o, fetch_valid_o, fetch_wid_o);
            check($sformatf("vec%0d.sel", i), 64'(warp_selected_o), 64'(tbl[i].sel));
            check_slot($sformatf("vec%0d", i), tbl[i].valid, int'(tbl[i].wid));
            next_cycle();
        end

        // Backpressure: wid 2 stalled for 5 cycles, then back-to-back handoff
        warp_ready_i = 4'b0100; fetch_ready_i = 1'b1;
        @(negedge clk_i);
        check("bp.grant.sel", 64'(warp_selected_o), 64'b0100);
        next_cycle();
        warp_ready_i = 4'b1011; fetch_ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk_i);
            $display("stall %0d sel=%b valid=%b wid=%0d pc=%0h",
                     c, warp_selected_o, fetch_valid_o, fetch_wid_o, fetch_pc_o);
            check("bp.stall.sel", 64'(warp_selected_o), 64'd0);
            check("bp.stall.pc",  64'(fetch_pc_o), 64'h40);
            check_slot("bp.stall", 1'b1, 2);
            next_cycle();
        end
        fetch_ready_i = 1'b1;
        @(negedge clk_i);
        check("bp.release.sel", 64'(warp_selected_o), 64'b1000);
        check_slot("bp.release", 1'b1, 2);
        next_cycle();
        warp_ready_i = 4'b0011;
        @(negedge clk_i);
        check("bp.next.sel", 64'(warp_selected_o), 64'b0001);
        check_slot("bp.next", 1'b1, 3);
        next_cycle();
        warp_ready_i = 4'b0000;
        @(negedge clk_i);
        check_slot("bp.tail", 1'b1, 0);
        next_cycle();

        // Async reset while a request is stalled
        warp_ready_i = 4'b0010; fetch_ready_i = 1'b1;
        @(negedge clk_i);
        check("ar.grant.sel", 64'(warp_selected_o), 64'b0010);
        next_cycle();
        warp_ready_i = 4'b0000; fetch_ready_i = 1'b0;
        @(negedge clk_i);
        check_slot("ar.stalled", 1'b1, 1);
        #2;
        rst_ni = 1'b0;
        #1;
        $display("async reset asserted: valid=%b wid=%0d", fetch_valid_o, fetch_wid_o);
        check("ar.valid", 64'(fetch_valid_o), 64'd0);
        check("ar.wid",   64'(fetch_wid_o), 64'd0);
        check("ar.sel",   64'(warp_selected_o), 64'd0);
        next_cycle();
        rst_ni = 1'b1;

        // Round robin with a stack model that re-arms a warp 3 cycles after selection
        fetch_ready_i = 1'b1;
        for (int w = 0; w < NW; w++) rearm_at[w] = 0;
        for (int k = 0; k < 8; k++) begin
            for (int w = 0; w < NW; w++) warp_ready_i[w] = (k >= rearm_at[w]);
            @(negedge clk_i);
            sel_seen = warp_selected_o;
            $display("rr %0d ready=%b sel=%b valid=%b wid=%0d",
                     k, warp_ready_i, sel_seen, fetch_valid_o, fetch_wid_o);
            check($sformatf("rr%0d.sel", k), 64'(sel_seen), 64'(4'b0001 << order[k]));
            if (k == 0) check_slot("rr0", 1'b0, 0);
            else        check_slot($sformatf("rr%0d", k), 1'b1, order[k-1]);
            for (int w = 0; w < NW; w++) if (sel_seen[w]) rearm_at[w] = k + 3;
            next_cycle();
        end
        warp_ready_i = 4'b0000;
        @(negedge clk_i);
        check_slot("rr.tail", 1'b1, 3);
        next_cycle();
        @(negedge clk_i);
        check_slot("rr.empty", 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
